// File: rtl/key_command_scheduler_if.sv
// Command handshake bundle between the key scheduler (master) and the game FSM (slave).
interface key_command_scheduler_if #(
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic            cmd_valid;
   logic [2:0]      cmd_code;
   logic            cmd_ready;
   logic [CntW-1:0] fifo_count;
   logic            dropped;

   modport master (
      output cmd_valid,
      output cmd_code,
      output fifo_count,
      output dropped,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_code,
      input  fifo_count,
      input  dropped,
      output cmd_ready
   );
endinterface

// File: rtl/key_command_scheduler.sv
// Turns held key levels into prioritised one-shot game commands with direction auto-repeat,
// queued in a show-ahead FIFO; restart/quit flush queued moves.
module key_command_scheduler #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned REPEAT_DELAY = 25000000,
   parameter int unsigned REPEAT_RATE  = 6250000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic up,
   input  logic down,
   input  logic left,
   input  logic right,
   input  logic space,
   input  logic restart,
   input  logic quit,
   input  logic select,
   key_command_scheduler_if.master cmd
);
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned CW     = AW + 1;
   localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW     = $clog2(RptMax);

   localparam logic [RW-1:0] DelayLoad = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RateLoad  = RW'(REPEAT_RATE - 1);

   localparam logic [2:0] CodeUp      = 3'd0;
   localparam logic [2:0] CodeDown    = 3'd1;
   localparam logic [2:0] CodeLeft    = 3'd2;
   localparam logic [2:0] CodeRight   = 3'd3;
   localparam logic [2:0] CodeSpace   = 3'd4;
   localparam logic [2:0] CodeRestart = 3'd5;
   localparam logic [2:0] CodeSelect  = 3'd6;
   localparam logic [2:0] CodeQuit    = 3'd7;

   // Bits for codes 0-4 and 6: the moves a flush discards.
   localparam logic [7:0] FlushMask = 8'h5F;

   logic [7:0]    keys;
   logic [7:0]    prev_q;
   logic [7:0]    pending_q, pending_d;
   logic          dropped_q;
   logic [2:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] count_q;
   logic          act_q, act_d;
   logic [1:0]    dir_q, dir_d;
   logic [RW-1:0] rpt_q, rpt_d;

   logic [7:0] rise, ev, clr;
   logic [3:0] rpt_ev;
   logic       top_valid, is_flush, full, pop, grant, push, flush, merged;
   logic [2:0] top_code;

   assign keys = {quit, select, restart, space, right, left, down, up};
   assign rise = keys & ~prev_q;

   // Typematic repeat for the most recently pressed direction only.
   always_comb begin
      rpt_ev = '0;
      act_d  = act_q;
      dir_d  = dir_q;
      rpt_d  = rpt_q;
      if (|rise[3:0]) begin
         act_d = 1'b1;
         rpt_d = DelayLoad;
         for (int i = 0; i < 4; i++) begin
            if (rise[i]) dir_d = i[1:0];
         end
      end else if (act_q) begin
         if (!keys[dir_q]) begin
            act_d = 1'b0;
         end else if (rpt_q == '0) begin
            rpt_ev[dir_q] = 1'b1;
            rpt_d         = RateLoad;
         end else begin
            rpt_d = rpt_q - 1'b1;
         end
      end
   end

   assign ev = rise | {4'b0000, rpt_ev};

   always_comb begin
      top_valid = 1'b1;
      if      (pending_q[CodeQuit])    top_code = CodeQuit;
      else if (pending_q[CodeRestart]) top_code = CodeRestart;
      else if (pending_q[CodeSelect])  top_code = CodeSelect;
      else if (pending_q[CodeSpace])   top_code = CodeSpace;
      else if (pending_q[CodeUp])      top_code = CodeUp;
      else if (pending_q[CodeDown])    top_code = CodeDown;
      else if (pending_q[CodeLeft])    top_code = CodeLeft;
      else if (pending_q[CodeRight])   top_code = CodeRight;
      else begin
         top_valid = 1'b0;
         top_code  = CodeUp;
      end
   end

   assign pop      = cmd.cmd_valid && cmd.cmd_ready;
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign is_flush = (top_code == CodeRestart) || (top_code == CodeQuit);
   assign grant    = top_valid && (is_flush || !full || pop);
   assign push     = grant && !is_flush;
   assign flush    = grant && is_flush;

   always_comb begin
      clr = '0;
      if (grant) clr[top_code] = 1'b1;
      if (flush) clr = clr | FlushMask;
   end

   // A new event re-arms a bit that is being cleared this edge.
   assign pending_d = (pending_q & ~clr) | ev;
   assign merged    = |(ev & pending_q & ~clr);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         prev_q    <= '0;
         pending_q <= '0;
         dropped_q <= 1'b0;
         act_q     <= 1'b0;
         dir_q     <= '0;
         rpt_q     <= '0;
      end else begin
         prev_q    <= keys;
         pending_q <= pending_d;
         dropped_q <= dropped_q | merged;
         act_q     <= act_d;
         dir_q     <= dir_d;
         rpt_q     <= rpt_d;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (flush) begin
         mem_q[0] <= top_code;
         rd_q     <= '0;
         wr_q     <= AW'(1);
         count_q  <= CW'(1);
      end else begin
         if (push) begin
            mem_q[wr_q] <= top_code;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign cmd.cmd_valid  = (count_q != '0);
   assign cmd.cmd_code   = cmd.cmd_valid ? mem_q[rd_q] : 3'd0;
   assign cmd.fifo_count = count_q;
   assign cmd.dropped    = dropped_q;

endmodule
